// File: rtl/addsub16_pkg.sv
// rtl/addsub16_pkg.sv - shared types, constants and golden model for the add/sub self-check engine
package addsub16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FIN
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Corner patterns indexed by idx 0..3; element [0] is the rightmost word.
    localparam logic [3:0][15:0] CORNER_A   = {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    localparam logic [3:0][15:0] CORNER_B   = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    localparam logic [3:0]       CORNER_ADD = 4'b0101;

    // Returns {O, C, S}; subtraction is A + ~B + 1, so C=1 means no borrow.
    function automatic logic [17:0] addsub16_ref(input logic [15:0] a,
                                                 input logic [15:0] b,
                                                 input logic        add);
        logic [16:0] r;
        logic        o;
        if (add) begin
            r = {1'b0, a} + {1'b0, b};
            o = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
            r = {1'b0, a} + {1'b0, ~b} + 17'd1;
            o = (a[15] != b[15]) && (r[15] != a[15]);
        end
        return {o, r};
    endfunction

endpackage

// File: rtl/addsub16_selfcheck_if.sv
// rtl/addsub16_selfcheck_if.sv - operand/response bus between the checker and the adder under test
interface addsub16_selfcheck_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        Add_ctrl;
    logic [15:0] SUM;
    logic        C_out;
    logic        O;

    modport master (output A, output B, output Add_ctrl,
                    input  SUM, input C_out, input O);
    modport slave  (input  A, input B, input Add_ctrl,
                    output SUM, output C_out, output O);
endinterface

// File: rtl/addsub16_lfsr32.sv
// rtl/addsub16_lfsr32.sv - 32-bit right-shifting Galois LFSR with synchronous load
import addsub16_pkg::*;

module addsub16_lfsr32 #(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (enable_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_POLY) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/addsub16_selfcheck.sv
// rtl/addsub16_selfcheck.sv - BIST pattern engine and response checker for a 16-bit add/sub datapath
import addsub16_pkg::*;

module addsub16_selfcheck #(
    parameter int          N_PATTERNS = 10000,
    parameter int          SETTLE_CYC = 1,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    addsub16_selfcheck_if.master          dut_if,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [16:0]                   err_cnt,
    output logic [15:0]                   first_err_idx
);

    localparam logic [15:0] LAST_IDX = 16'(N_PATTERNS - 1);
    localparam logic [16:0] ERR_MAX  = 17'h1FFFF;

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        ctrl_q, ctrl_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [16:0] err_q, err_d;
    logic [15:0] fei_q, fei_d;

    logic        lfsr_en, lfsr_load;
    logic [31:0] lfsr_state;
    logic [15:0] idx_nxt;
    logic [17:0] gold;
    logic        mis_s, mis_c, mis_o;
    logic [17:0] err_sum;

    addsub16_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (lfsr_en),
        .load_i   (lfsr_load),
        .seed_i   (SEED),
        .state_o  (lfsr_state)
    );

    // Response check against the operands currently held on the bus.
    assign gold    = addsub16_ref(a_q, b_q, ctrl_q);
    assign mis_s   = (dut_if.SUM   !== gold[15:0]);
    assign mis_c   = (dut_if.C_out !== gold[16]);
    assign mis_o   = (dut_if.O     !== gold[17]);
    assign err_sum = {1'b0, err_q} + {17'd0, mis_s} + {17'd0, mis_c} + {17'd0, mis_o};
    assign idx_nxt = idx_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fei_d     = fei_q;
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d     = '0;
                    fei_d     = 16'hFFFF;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    lfsr_load = 1'b1;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (idx_q < 16'd4) begin
                    a_d    = CORNER_A[idx_q[1:0]];
                    b_d    = CORNER_B[idx_q[1:0]];
                    ctrl_d = CORNER_ADD[idx_q[1:0]];
                end else begin
                    a_d    = lfsr_state[15:0];
                    b_d    = lfsr_state[31:16];
                    ctrl_d = lfsr_state[0] ^ idx_q[0];
                end
                if (SETTLE_CYC == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d  = 4'(SETTLE_CYC - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_CHECK: begin
                err_d = err_sum[17] ? ERR_MAX : err_sum[16:0];
                // err_q only leaves zero on a mismatch, so it marks the first failing pattern.
                if ((mis_s || mis_c || mis_o) && (err_q == 17'd0)) begin
                    fei_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_nxt;
                    lfsr_en = (idx_nxt >= 16'd4);
                    state_d = ST_DRIVE;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == 17'd0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fei_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fei_q   <= fei_d;
        end
    end

    assign dut_if.A        = a_q;
    assign dut_if.B        = b_q;
    assign dut_if.Add_ctrl = ctrl_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_addsub16_selfcheck.sv
// tb/tb_addsub16_selfcheck.sv - bench for addsub16_selfcheck with reference pattern/arithmetic model
module tb_addsub16_selfcheck;

    localparam int          N_MAIN = 10000;
    localparam int          N_FAST = 100;
    localparam logic [31:0] SEED   = 32'hACE1_2468;
    localparam logic [31:0] POLY   = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_m = 1'b0;
    logic start_f = 1'b0;
    int   fault_f = 0;

    always #5 clk = ~clk;

    addsub16_selfcheck_if if_m ();
    addsub16_selfcheck_if if_f ();

    logic        busy_m, done_m, pass_m, busy_f, done_f, pass_f;
    logic [16:0] err_m, err_f;
    logic [15:0] fei_m, fei_f;

    addsub16_selfcheck u_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .dut_if(if_m),
        .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_cnt(err_m), .first_err_idx(fei_m)
    );

    addsub16_selfcheck #(.N_PATTERNS(N_FAST), .SETTLE_CYC(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_f), .dut_if(if_f),
        .busy(busy_f), .done(done_f), .pass(pass_f),
        .err_cnt(err_f), .first_err_idx(fei_f)
    );

    // Arithmetic reference: plain integer add/subtract, signed range test for overflow.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic add);
        int ua, ub, ur, sa, sb, sr;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = add ? ua + ub : ua - ub;
        sr = add ? sa + sb : sa - sb;
        c  = add ? (ur > 65535) : (ur >= 0);
        o  = (sr > 32767) || (sr < -32768);
        return {o, c, ur[15:0]};
    endfunction

    logic [17:0] resp_m, resp_f;
    assign resp_m = model(if_m.A, if_m.B, if_m.Add_ctrl);
    assign resp_f = model(if_f.A, if_f.B, if_f.Add_ctrl);

    assign if_m.SUM   = resp_m[15:0];
    assign if_m.C_out = resp_m[16];
    assign if_m.O     = resp_m[17];
    assign if_f.SUM   = resp_f[15:0] ^ ((fault_f == 2) ? 16'h0001 : 16'h0000);
    assign if_f.C_out = resp_f[16];
    assign if_f.O     = (fault_f == 1) ? 1'b0 : resp_f[17];

    int          sel = 0;
    logic [15:0] o_a, o_b, o_fei;
    logic        o_ctrl, o_busy, o_done, o_pass;
    logic [16:0] o_err;
    logic [17:0] o_resp;
    assign o_a    = sel ? if_f.A        : if_m.A;
    assign o_b    = sel ? if_f.B        : if_m.B;
    assign o_ctrl = sel ? if_f.Add_ctrl : if_m.Add_ctrl;
    assign o_resp = sel ? {if_f.O, if_f.C_out, if_f.SUM} : {if_m.O, if_m.C_out, if_m.SUM};
    assign o_busy = sel ? busy_f : busy_m;
    assign o_done = sel ? done_f : done_m;
    assign o_pass = sel ? pass_f : pass_m;
    assign o_err  = sel ? err_f  : err_m;
    assign o_fei  = sel ? fei_f  : fei_m;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_pat [$];
    logic [32:0] got_pat [$];
    logic [17:0] got_resp [$];
    int          cycles;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start_f = v;
        else          start_m = v;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".A"},    64'(o_a), 64'h0);
        chk({tag, ".B"},    64'(o_b), 64'h0);
        chk({tag, ".ctrl"}, 64'(o_ctrl), 64'h0);
        chk({tag, ".busy"}, 64'(o_busy), 64'h0);
        chk({tag, ".done"}, 64'(o_done), 64'h0);
        chk({tag, ".pass"}, 64'(o_pass), 64'h0);
        chk({tag, ".err"},  64'(o_err), 64'h0);
        chk({tag, ".fei"},  64'(o_fei), 64'hFFFF);
    endtask

    // Runs one pass on the selected instance, capturing each driven pattern on the
    // cycle after it is registered. Returns clock edges from the start-sampling edge to done.
    task automatic run(input int n, input int settle, input int extra_start_at,
                       input int rst_at, output int edges);
        bit aborted;
        int guard;
        aborted = 0;
        got_pat.delete();
        got_resp.delete();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        set_start(1'b0);
        chk("start.busy", 64'(o_busy), 64'h1);
        chk("start.done_cleared", 64'(o_done), 64'h0);
        for (int k = 0; k < n; k++) begin
            for (int e = 0; e < settle + 2; e++) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                set_start(1'b0);
                if (e == 0) begin
                    got_pat.push_back({o_ctrl, o_b, o_a});
                    got_resp.push_back(o_resp);
                    if (k == extra_start_at) set_start(1'b1);
                    if (k == rst_at) begin
                        rst_n = 1'b0;
                        #1;
                        chk_reset_vals("midrun_reset");
                        aborted = 1;
                        break;
                    end
                end
            end
            if (aborted) break;
        end
        if (!aborted) begin
            guard = 0;
            while (!o_done && guard < 8) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                guard++;
            end
        end
    endtask

    task automatic chk_patterns(input string tag, input int n);
        int bad;
        bad = 0;
        chk({tag, ".count"}, 64'(got_pat.size()), 64'(n));
        for (int k = 0; k < n && k < got_pat.size(); k++) begin
            if (got_pat[k] !== exp_pat[k]) begin
                if (bad < 4) chk($sformatf("%s.pat%0d", tag, k), 64'(got_pat[k]), 64'(exp_pat[k]));
                bad++;
            end
        end
        chk({tag, ".bad_patterns"}, 64'(bad), 64'h0);
    endtask

    initial begin
        logic [31:0] lfsr;
        int          n_ovf;
        lfsr = SEED;
        exp_pat.push_back({1'b1, 16'h0001, 16'h7FFF});
        exp_pat.push_back({1'b0, 16'h0001, 16'h8000});
        exp_pat.push_back({1'b1, 16'h0001, 16'hFFFF});
        exp_pat.push_back({1'b0, 16'h0001, 16'h0000});
        for (int i = 4; i < N_MAIN; i++) begin
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
            exp_pat.push_back({lfsr[0] ^ (i % 2 == 1), lfsr[31:16], lfsr[15:0]});
        end
        n_ovf = 0;
        for (int i = 0; i < N_FAST; i++) begin
            logic [17:0] r;
            r = model(exp_pat[i][15:0], exp_pat[i][31:16], exp_pat[i][32]);
            if (r[17]) n_ovf++;
        end

        repeat (3) @(negedge clk);
        sel = 0; #1 chk_reset_vals("reset_main");
        sel = 1; #1 chk_reset_vals("reset_fast");
        @(negedge clk);
        rst_n = 1'b1;

        // Full default run against a correct adder.
        sel = 0;
        run(N_MAIN, 1, -1, -1, cycles);
        chk("main.cycles", 64'(cycles), 64'(1 + N_MAIN * 3));
        chk("main.done", 64'(o_done), 64'h1);
        chk("main.pass", 64'(o_pass), 64'h1);
        chk("main.err", 64'(o_err), 64'h0);
        chk("main.fei", 64'(o_fei), 64'hFFFF);
        chk_patterns("main", N_MAIN);
        chk("corner0.resp", 64'(got_resp[0]), 64'({1'b1, 1'b0, 16'h8000}));
        chk("corner1.resp", 64'(got_resp[1]), 64'({1'b1, 1'b1, 16'h7FFF}));
        chk("corner2.resp", 64'(got_resp[2]), 64'({1'b0, 1'b1, 16'h0000}));
        chk("corner3.resp", 64'(got_resp[3]), 64'({1'b0, 1'b0, 16'hFFFF}));
        repeat (5) @(negedge clk);
        chk("main.done_sticky", 64'(o_done), 64'h1);
        chk("main.busy_after", 64'(o_busy), 64'h0);
        chk("main.A_hold", 64'(o_a), 64'(exp_pat[N_MAIN-1][15:0]));

        // Zero-settle instance: extra start while busy must not disturb the run.
        sel = 1;
        fault_f = 0;
        run(N_FAST, 0, 20, -1, cycles);
        chk("busy_start.cycles", 64'(cycles), 64'(1 + 2 * N_FAST));
        chk("busy_start.pass", 64'(o_pass), 64'h1);
        chk("busy_start.err", 64'(o_err), 64'h0);
        chk("busy_start.fei", 64'(o_fei), 64'hFFFF);
        chk_patterns("busy_start", N_FAST);
        repeat (3) @(negedge clk);
        chk("busy_start.no_rerun", 64'(o_busy), 64'h0);

        fault_f = 1;
        run(N_FAST, 0, -1, -1, cycles);
        chk("ostuck.cycles", 64'(cycles), 64'(1 + 2 * N_FAST));
        chk("ostuck.pass", 64'(o_pass), 64'h0);
        chk("ostuck.err", 64'(o_err), 64'(n_ovf));
        chk("ostuck.fei", 64'(o_fei), 64'h0);

        fault_f = 2;
        run(N_FAST, 0, -1, -1, cycles);
        chk("sum0.pass", 64'(o_pass), 64'h0);
        chk("sum0.err", 64'(o_err), 64'(N_FAST));
        chk("sum0.fei", 64'(o_fei), 64'h0);

        fault_f = 0;
        run(N_FAST, 0, -1, 50, cycles);
        chk_patterns("pre_reset", 51);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(N_FAST, 0, -1, -1, cycles);
        chk("rerun.cycles", 64'(cycles), 64'(1 + 2 * N_FAST));
        chk("rerun.pass", 64'(o_pass), 64'h1);
        chk("rerun.err", 64'(o_err), 64'h0);
        chk_patterns("rerun", N_FAST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub16_selfcheck.md
Name: addsub16_selfcheck

Overview:
- Synthesizable on-chip pattern engine and response checker for the 16-bit add/sub datapath (A, B, Add_ctrl in; SUM, C_out, O out).
- Drives operand patterns into the DUT and samples its combinational response.
- Compares the response against an internal golden model and accumulates error counts.
- Sits beside the adder as a BIST wrapper, so the adder can be verified in silicon or FPGA without file-based vectors.

Parameters:
- N_PATTERNS, 10000: total patterns per run, including the 4 fixed corner patterns; legal range 4..65535.
- SETTLE_CYC, 1: wait cycles between driving operands and sampling the response; legal range 0..15.
- SEED, 32'hACE1_2468: LFSR reset/start value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- A  out  16  operand A to DUT.
- B  out  16  operand B to DUT.
- Add_ctrl  out  1  1 = add (A+B), 0 = subtract (A-B).
- SUM  in  16  DUT result.
- C_out  in  1  DUT carry-out.
- O  in  1  DUT signed overflow.
- busy  out  1  run in progress.
- done  out  1  run complete; sticky until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  17  mismatch count, saturating at 17'h1FFFF.
- first_err_idx  out  16  0-based index of the first failing pattern; 16'hFFFF if none.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; A=B=0, Add_ctrl=0.
  - busy=0, done=0, pass=0, err_cnt=0, first_err_idx=16'hFFFF.
  - LFSR=SEED, idx=0, wait counter=0.
- Reset mid-run aborts immediately to the above values. No partial results are retained.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, FIN.
  - IDLE: on start=1, clear err_cnt, first_err_idx, done and pass; load LFSR=SEED, idx=0; go to DRIVE. busy=1 from the next cycle.
  - DRIVE: register A/B/Add_ctrl for pattern idx. If SETTLE_CYC==0 go to CHECK, else go to SETTLE with wait=SETTLE_CYC-1.
  - SETTLE: decrement wait; go to CHECK when wait==0.
  - CHECK: sample SUM/C_out/O against the golden result of the currently driven A/B/Add_ctrl.
    - Add 1 to err_cnt for each mismatching field (SUM, C_out, O), so at most 3 per pattern. Saturate, no wrap.
    - On the first pattern with any mismatch, capture first_err_idx=idx.
    - If idx==N_PATTERNS-1 go to FIN; else idx++, advance LFSR if the next pattern is an LFSR pattern, go to DRIVE.
  - FIN: busy=0, done=1, pass=(err_cnt==0); go to IDLE.
- Cycles per pattern: SETTLE_CYC+2.
- Total run time from start pulse to done=1: 1 + N_PATTERNS*(SETTLE_CYC+2) cycles.
- A/B/Add_ctrl hold their last values after FIN.
- start is ignored while busy=1. start in the same cycle as FIN's transition to IDLE is also ignored; it is accepted only in IDLE.
- Pattern source:
  - idx 0: A=7FFF, B=0001, add.
  - idx 1: A=8000, B=0001, sub.
  - idx 2: A=FFFF, B=0001, add.
  - idx 3: A=0000, B=0001, sub.
  - idx>=4: A=LFSR[15:0], B=LFSR[31:16], Add_ctrl=LFSR[0]^idx[0].
  - The LFSR is Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifted right once per LFSR pattern. It is first advanced before idx 4, so idx 4 uses step(SEED).
- Golden model (17-bit arithmetic):
  - add: {C,S}=A+B; O=(A[15]==B[15])&&(S[15]!=A[15]).
  - sub: {C,S}=A+~B+1, so C=1 means no borrow (A>=B unsigned); O=(A[15]!=B[15])&&(S[15]!=A[15]).
- X/Z on SUM/C_out/O counts as a mismatch; comparison uses case-inequality semantics in simulation.

Decomposition:
- Package addsub16_pkg holds:
  - state enum;
  - LFSR_POLY=32'h8020_0003;
  - the four corner-pattern constants;
  - golden function addsub16_ref(a,b,add) returning {O,C,S}.
- One sub-module: addsub16_lfsr32 (enable, load, seed in; 32-bit state out).
- Checker FSM, counters and comparison stay in the top.

Test Plan:
- Correct combinational adder attached, defaults -> done after 1+10000*3=30001 cycles; pass=1, err_cnt=0, first_err_idx=FFFF.
- Corner patterns checked individually:
  - idx0 expects SUM=8000, C=0, O=1.
  - idx1 expects 7FFF, C=1, O=1.
  - idx2 expects 0000, C=1, O=0.
  - idx3 expects FFFF, C=0, O=0.
- DUT with O stuck at 0 -> pass=0, first_err_idx=0, err_cnt equals the golden count of overflow patterns (bench-computed).
- DUT with SUM bit 0 inverted and N_PATTERNS=100 -> err_cnt=100, first_err_idx=0.
- rst_n pulsed low at pattern 50 -> all outputs return to reset values within the same cycle. A new start then reproduces the identical A/B sequence from idx 0.
- start pulsed while busy, and SETTLE_CYC=0 -> the extra start has no effect; run length is 1+2*N_PATTERNS cycles.
